// File: rtl/dpram_fifo_pkg.sv
// Shared types and default widths for the dual-port-RAM FIFO controller.
//   DATA_WIDTH : default RAM word width
//   ADDR_WIDTH : default RAM address width (depth = 2**ADDR_WIDTH)
//   rd_state_e : read-side state (IDLE = no head word presented, VALID = head on rd_data)
package dpram_fifo_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } rd_state_e;

endpackage

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller for a single-clock true dual-port RAM with registered outputs.
// Port A of the RAM is the write side, port B the read side. This block owns the
// pointers, the occupancy count and the read-data hold logic; the RAM sits beside
// it in the parent.
//
// Optional feature: define DPRAM_FIFO_ALMOST_FULL_EN to enable a registered
// almost_full flag (count >= AF_LEVEL); otherwise almost_full is tied low.
//
// Ports:
//   clk, rst            clock shared with the RAM, async active-high reset
//   wr_valid/ready/data producer stream
//   rd_valid/ready/data consumer stream (rd_data comes straight from ram_q_b)
//   count               words stored and not yet consumed (0..DEPTH)
//   almost_full         count >= AF_LEVEL (optional)
//   ram_*               RAM port A (write) / port B (read) controls, ram_q_b input
module dpram_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = dpram_fifo_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = dpram_fifo_pkg::ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  ram_we_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);
    import dpram_fifo_pkg::*;

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = CW'(1 << ADDR_WIDTH);

    rd_state_e             state;
    rd_state_e             state_next;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] fetch_ptr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH:0]   unfetched;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  issue;

    // Stream handshakes and RAM port wiring
    assign wr_ready   = (count != DEPTH);
    assign wr_fire    = wr_valid && wr_ready;
    assign rd_valid   = (state == VALID);
    assign rd_fire    = rd_valid && rd_ready;
    assign rd_data    = ram_q_b;
    assign ram_addr_a = wr_ptr;
    assign ram_data_a = wr_data;
    assign ram_we_a   = wr_fire;
    assign ram_data_b = '0;
    assign ram_we_b   = 1'b0;
    // When not fetching, re-read the held slot so q_b stays stable under stall
    assign ram_addr_b = issue ? fetch_ptr : last_addr;

    // Read FSM next state; a fetch is launched when a stored word has not yet
    // been read out and the output register is empty or being drained
    always_comb begin
        state_next = state;
        unfetched  = count - CW'(state == VALID);
        issue      = (unfetched != '0) && ((state == IDLE) || rd_ready);
        count_next = count + CW'(wr_fire) - CW'(rd_fire);
        if (issue) begin
            state_next = VALID;
        end else if ((state == VALID) && rd_ready) begin
            state_next = IDLE;
        end
    end

    // State, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            fetch_ptr <= '0;
            last_addr <= '0;
            count     <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (issue) begin
                last_addr <= fetch_ptr;
                fetch_ptr <= fetch_ptr + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef DPRAM_FIFO_ALMOST_FULL_EN
    // Registered from the next count so the flag lines up with count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (32'(count_next) >= AF_LEVEL);
        end
    end
`else
    logic unused_af_level;
    assign unused_af_level = ^AF_LEVEL;
    assign almost_full     = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural dual-port RAM beside it.
// Expected read data comes from a queue filled on accepted writes; a monitor pops
// and compares on every read handshake and checks count/flags against a word count.
module tb_dpram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int AF    = 56;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic          almost_full;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_data_a;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_data_b;
    logic          ram_we_b;
    logic [DW-1:0] ram_q_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pop    = 0;
    int model_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count), .almost_full(almost_full),
        .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
        .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_we_b(ram_we_b),
        .ram_q_b(ram_q_b)
    );

    // Behavioural true dual-port RAM, registered read, old data on same-address access
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: sampled mid-cycle, inputs change just after posedge
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_ready;
            exp_ready = (model_cnt != DEPTH);
            chk("count", 32'(count), 32'(model_cnt));
            chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
            chk("ram_we_a", 32'(ram_we_a), 32'(wr_valid && exp_ready));
            chk("ram_data_a", 32'(ram_data_a), 32'(wr_data));
            chk("ram_port_b_idle", {ram_we_b, ram_data_b}, 32'(0));
`ifdef DPRAM_FIFO_ALMOST_FULL_EN
            chk("almost_full", 32'(almost_full), 32'(model_cnt >= AF));
`else
            chk("almost_full_off", 32'(almost_full), 32'(0));
`endif
            if (model_cnt == 0) chk("rd_valid_when_empty", 32'(rd_valid), 32'(0));
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_from_empty", 32'(1), 32'(0));
                end else begin
                    chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                    n_pop++;
                end
            end
            if (wr_valid && exp_ready) exp_q.push_back(wr_data);
            model_cnt = model_cnt + int'(wr_valid && exp_ready) - int'(rd_valid && rd_ready);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int k;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        k = 0;
        while ((model_cnt != 0) && (k < 300)) begin
            step();
            k++;
        end
        step();
        chk("drain_count", 32'(count), 32'(0));
        chk("drain_rd_valid", 32'(rd_valid), 32'(0));
    endtask

    initial begin
        int p0;
        reset_dut();
        chk("reset_rd_valid", 32'(rd_valid), 32'(0));
        chk("reset_count", 32'(count), 32'(0));
        chk("reset_wr_ready", 32'(wr_ready), 32'(1));

        // Back-to-back 0x11/0x22/0x33 with consumer ready: 2-edge latency, 1 word/cycle
        rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 8'h11;
        step();
        chk("t1_latency_e0", 32'(rd_valid), 32'(0));
        wr_data = 8'h22;
        step();
        chk("t1_valid_e1", 32'(rd_valid), 32'(1));
        chk("t1_data_11", 32'(rd_data), 32'h11);
        wr_data = 8'h33;
        step();
        wr_valid = 1'b0;
        chk("t1_valid_e2", 32'(rd_valid), 32'(1));
        chk("t1_data_22", 32'(rd_data), 32'h22);
        step();
        chk("t1_valid_e3", 32'(rd_valid), 32'(1));
        chk("t1_data_33", 32'(rd_data), 32'h33);
        step();
        chk("t1_empty", 32'(rd_valid), 32'(0));
        chk("t1_count0", 32'(count), 32'(0));

        // Fill to full, refuse an extra word, drain in order
        rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1; wr_data = DW'(i);
            step();
        end
        wr_data = 8'hFF;
        chk("t2_full_ready", 32'(wr_ready), 32'(0));
        chk("t2_full_count", 32'(count), 32'(DEPTH));
        // Full with consumer taking a word in the same cycle: still refused
        rd_ready = 1'b1;
        chk("t2_full_rd_ready", 32'(wr_ready), 32'(0));
        step();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("t2_after_refuse", 32'(count), 32'(DEPTH - 1));
        p0 = n_pop;
        drain();
        chk("t2_pops", 32'(n_pop - p0), 32'(DEPTH - 1));

        // Stall with head 0xA5 while writes continue
        wr_valid = 1'b1; wr_data = 8'hA5; rd_ready = 1'b0;
        step();
        wr_data = DW'($urandom);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_valid", 32'(rd_valid), 32'(1));
            chk("t3_stall_data", 32'(rd_data), 32'hA5);
            wr_data = DW'($urandom);
            step();
        end
        drain();

        // Random traffic across pointer wrap
        for (int i = 0; i < 200; i++) begin
            wr_valid = ($urandom_range(0, 99) < 60);
            wr_data  = DW'($urandom);
            rd_ready = ($urandom_range(0, 99) < 50);
            step();
        end
        drain();

        // Almost-full threshold: 55 -> 56 -> 55
        rd_ready = 1'b0;
        for (int i = 0; i < AF - 1; i++) begin
            wr_valid = 1'b1; wr_data = DW'(i + 3);
            step();
        end
        wr_valid = 1'b0;
        step();
        chk("t6_af_at_55", 32'(almost_full), 32'(0));
        wr_valid = 1'b1; wr_data = 8'hC3;
        step();
        wr_valid = 1'b0;
        step();
`ifdef DPRAM_FIFO_ALMOST_FULL_EN
        chk("t6_af_at_56", 32'(almost_full), 32'(1));
`else
        chk("t6_af_off", 32'(almost_full), 32'(0));
`endif
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        step();
        chk("t6_af_back_55", 32'(almost_full), 32'(0));
        drain();

        // Async reset mid-stream with 10 words stored
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_data = DW'(8'h80 + i);
            step();
        end
        wr_valid = 1'b0;
        #1;
        rst = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        #1;
        chk("t5_async_rd_valid", 32'(rd_valid), 32'(0));
        chk("t5_async_count", 32'(count), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("t5_wr_ready", 32'(wr_ready), 32'(1));
        wr_valid = 1'b1; wr_data = 8'h5A;
        step();
        wr_valid = 1'b0;
        step();
        chk("t5_valid", 32'(rd_valid), 32'(1));
        chk("t5_fresh_data", 32'(rd_data), 32'h5A);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- FIFO controller that drives the single-clock true dual-port RAM (8-bit data, 6-bit address, registered q_a/q_b).
- Port A is the write side; port B is the read side.
- Presents valid/ready streaming interfaces on both sides, so a producer stage can feed the RAM and a consumer stage can drain it.
- The RAM is instantiated beside this block in the parent; this block owns all pointers, occupancy and read-data hold logic.

Parameters:
- DATA_WIDTH, 8, word width; must match the RAM.
- ADDR_WIDTH, 6, RAM address width; DEPTH = 2**ADDR_WIDTH = 64 entries.
- AF_LEVEL, 56, almost-full threshold; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  producer has a word.
- wr_ready  out  1  FIFO accepts a word this cycle.
- wr_data  in  DATA_WIDTH  producer word.
- rd_valid  out  1  rd_data holds the head word.
- rd_ready  in  1  consumer takes the head word.
- rd_data  out  DATA_WIDTH  head word; wired straight from ram_q_b.
- count  out  ADDR_WIDTH+1  words stored and not yet consumed, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL (optional feature).
- ram_addr_a  out  ADDR_WIDTH  RAM port A address, equal to wr_ptr.
- ram_data_a  out  DATA_WIDTH  equal to wr_data.
- ram_we_a  out  1  equal to wr_valid && wr_ready.
- ram_addr_b  out  ADDR_WIDTH  RAM port B address.
- ram_data_b  out  DATA_WIDTH  tied 0.
- ram_we_b  out  1  tied 0.
- ram_q_b  in  DATA_WIDTH  RAM port B registered read data.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - wr_ptr = 0, fetch_ptr = 0, last_addr = 0, count = 0, state = IDLE.
  - rd_valid = 0 and almost_full = 0 immediately; wr_ready = 1 once rst deasserts.
  - RAM contents are not cleared and are ignored.
- Write side:
  - wr_ready = (count != DEPTH), from registered count only; no combinational path from rd_ready.
  - Accepted write: RAM written at the edge; wr_ptr increments, wrapping at DEPTH.
- Read FSM, two states:
  - IDLE: rd_valid = 0.
  - VALID: rd_valid = 1.
  - unfetched = count − (state == VALID).
  - issue = (unfetched != 0) && (state == IDLE || rd_ready).
  - ram_addr_b = issue ? fetch_ptr : last_addr. When not issuing, the RAM re-reads the held slot, so q_b is stable under stall.
  - On issue: last_addr <= fetch_ptr; fetch_ptr increments with wrap; next state = VALID.
  - No issue: VALID with rd_ready -> IDLE; otherwise the state holds.
- Collision: issue only targets slots written at an earlier edge, and wr_ptr never equals the held slot while it is occupied. No same-address same-edge read/write ever occurs.
- Latency and throughput:
  - Write accepted at edge E0 into an empty FIFO -> issue in the following cycle -> rd_valid = 1 after edge E1 (2 edges).
  - Sustained throughput is one word per cycle in each direction.
- count update: +1 on an accepted write, −1 on rd_valid && rd_ready, unchanged when both occur.
- Boundaries:
  - Full, with rd consuming in the same cycle: the write is still refused that cycle.
  - Empty: rd_ready is ignored.
  - Pointers wrap modulo DEPTH with no flag.

Optional Feature:
- Macro DPRAM_FIFO_ALMOST_FULL_EN.
- Defined: almost_full is registered, next value (next count >= AF_LEVEL), so it is aligned with count.
- Undefined: almost_full is tied 0 and AF_LEVEL is unused.

Decomposition:
- Package dpram_fifo_pkg holds:
  - the read-state enum {IDLE, VALID};
  - default width constants DATA_WIDTH = 8 and ADDR_WIDTH = 6.
- No internal sub-module is required. The RAM (true_dpram_sclk) is instantiated alongside this block by the parent, not inside it.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 back-to-back with rd_ready = 1 -> rd_data is 0x11, 0x22, 0x33 on consecutive cycles; the first rd_valid arrives 2 edges after the 0x11 write; count ends at 0.
- Write 64 words 0x00..0x3F with rd_ready = 0 -> wr_ready = 0 and count = 64. An extra write of 0xFF is refused. Then drain -> 0x00..0x3F in order, and 0xFF never appears.
- Hold rd_ready = 0 for 5 cycles with head 0xA5 while writes continue -> rd_data remains 0xA5 and rd_valid remains 1 throughout.
- Run 200 random valid/ready cycles crossing pointer wrap -> the output sequence equals the input sequence and count matches a scoreboard each cycle.
- Assert rst mid-stream with count = 10 -> rd_valid and count drop to 0 asynchronously. After release, writing 0x5A yields rd_data 0x5A, not stale data.
- With DPRAM_FIFO_ALMOST_FULL_EN defined and AF_LEVEL = 56 -> almost_full rises at count = 56 and falls at count = 55.
